// File: rtl/candidate_issuer.sv
// candidate_issuer: accepts a candidate bit vector and issues the set positions
// one per cycle in ascending order over a valid/ready handshake.
// Optional feature: define CANDIDATE_ISSUER_SLOT_EN to add out_slot, the
// zero-based issue ordinal (compacted table address) of the current candidate.
module candidate_issuer #(
  parameter  int unsigned bs      = 16,
  localparam int unsigned bs_bits = $clog2(bs)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [0:bs-1]      candidate_list,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [bs_bits-1:0] out_index,
  output logic               out_last,
  output logic [bs_bits:0]   total,
`ifdef CANDIDATE_ISSUER_SLOT_EN
  output logic               done,
  output logic [bs_bits-1:0] out_slot
`else
  output logic               done
`endif
);

  localparam int unsigned tot_w = bs_bits + 1;

  localparam logic [0:0] st_idle  = 1'b0;
  localparam logic [0:0] st_issue = 1'b1;

  logic [0:0]         state, state_nxt;
  logic [0:bs-1]      pending, pending_nxt;
  logic [tot_w-1:0]   total_nxt;
  logic               done_nxt;
`ifdef CANDIDATE_ISSUER_SLOT_EN
  logic [bs_bits-1:0] slot_nxt;
`endif

  // Lowest set position of a vector (bit 0 is the leftmost position).
  function automatic logic [bs_bits-1:0] lowest_pos(input logic [0:bs-1] v);
    lowest_pos = '0;
    for (int i = int'(bs) - 1; i >= 0; i--) begin
      if (v[i]) lowest_pos = bs_bits'(i);
    end
  endfunction

  // Number of set positions in a vector.
  function automatic logic [tot_w-1:0] pop_count(input logic [0:bs-1] v);
    pop_count = '0;
    for (int i = 0; i < int'(bs); i++) begin
      pop_count = pop_count + tot_w'(v[i]);
    end
  endfunction

  // Next-state logic: load in IDLE, one issue per accepted transfer in ISSUE.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    total_nxt   = total;
    done_nxt    = 1'b0;
`ifdef CANDIDATE_ISSUER_SLOT_EN
    slot_nxt    = out_slot;
`endif
    case (state)
      st_idle: begin
        if (load_valid) begin
          pending_nxt = candidate_list;
          total_nxt   = pop_count(candidate_list);
`ifdef CANDIDATE_ISSUER_SLOT_EN
          slot_nxt    = '0;
`endif
          if (|candidate_list) state_nxt = st_issue;
          else                 done_nxt  = 1'b1;
        end
      end
      st_issue: begin
        if (out_ready) begin
          pending_nxt[out_index] = 1'b0;
`ifdef CANDIDATE_ISSUER_SLOT_EN
          slot_nxt = out_slot + bs_bits'(1);
`endif
          if (out_last) begin
            state_nxt = st_idle;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  // State and registered outputs; the issue outputs are precomputed from the
  // next pending vector so a load shows its first candidate one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= st_idle;
      pending    <= '0;
      total      <= '0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_index  <= '0;
      load_ready <= 1'b1;
`ifdef CANDIDATE_ISSUER_SLOT_EN
      out_slot   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      total      <= total_nxt;
      done       <= done_nxt;
      out_valid  <= (state_nxt == st_issue);
      out_last   <= (state_nxt == st_issue) && (pop_count(pending_nxt) == tot_w'(1));
      out_index  <= lowest_pos(pending_nxt);
      load_ready <= (state_nxt == st_idle);
`ifdef CANDIDATE_ISSUER_SLOT_EN
      out_slot   <= slot_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_candidate_issuer.sv
// Directed self-checking bench for candidate_issuer (bs = 16).
module tb_candidate_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [0:15] candidate_list;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_last;
  logic [4:0]  total;
  logic        done;
`ifdef CANDIDATE_ISSUER_SLOT_EN
  logic [3:0]  out_slot;
`endif

  int checks = 0;
  int errors = 0;

  candidate_issuer #(.bs(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .candidate_list (candidate_list),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_index      (out_index),
    .out_last       (out_last),
    .total          (total),
`ifdef CANDIDATE_ISSUER_SLOT_EN
    .done           (done),
    .out_slot       (out_slot)
`else
    .done           (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_idx [3];
    rst = 1'b1; load_valid = 1'b0; out_ready = 1'b0; candidate_list = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(load_ready), 64'd1);
    check("rst_total", 64'(total), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_last",  64'(out_last), 64'd0);

    // Sparse vector: positions 1, 10, 15 issued back to back
    exp_idx[0] = 4'd1; exp_idx[1] = 4'd10; exp_idx[2] = 4'd15;
    candidate_list = 16'b0100_0000_0010_0001; load_valid = 1'b1; out_ready = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sp_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("sp_index%0d", k), 64'(out_index), 64'(exp_idx[k]));
      check($sformatf("sp_last%0d", k),  64'(out_last), 64'(k == 2));
      check($sformatf("sp_ready%0d", k), 64'(load_ready), 64'd0);
      check($sformatf("sp_done%0d", k),  64'(done), 64'd0);
      step();
    end
    check("sp_end_valid", 64'(out_valid), 64'd0);
    check("sp_end_done",  64'(done), 64'd1);
    check("sp_end_total", 64'(total), 64'd3);
    check("sp_end_ready", 64'(load_ready), 64'd1);
    step();
    check("sp_done_pulse", 64'(done), 64'd0);

    // All-zero vector
    candidate_list = 16'h0000; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("z_valid", 64'(out_valid), 64'd0);
    check("z_done",  64'(done), 64'd1);
    check("z_total", 64'(total), 64'd0);
    check("z_ready", 64'(load_ready), 64'd1);
    step();
    check("z_done_pulse", 64'(done), 64'd0);
    check("z_valid2", 64'(out_valid), 64'd0);

    // Full vector with out_ready toggling
    candidate_list = 16'hFFFF; load_valid = 1'b1; out_ready = 1'b0;
    step();
    load_valid = 1'b0;
    check("f_total", 64'(total), 64'd16);
    for (int k = 0; k < 16; k++) begin
      out_ready = 1'b0;
      step();
      check($sformatf("f_stall_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("f_stall_index%0d", k), 64'(out_index), 64'(k));
      check($sformatf("f_stall_last%0d", k),  64'(out_last), 64'(k == 15));
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    check("f_end_valid", 64'(out_valid), 64'd0);
    check("f_end_done",  64'(done), 64'd1);
    check("f_end_total", 64'(total), 64'd16);

    // Reset mid-issue beats a simultaneous final transfer
    step();
    candidate_list = 16'h8001; load_valid = 1'b1; out_ready = 1'b1;
    step();
    load_valid = 1'b0;
    check("r_index0", 64'(out_index), 64'd0);
    step();
    check("r_index1", 64'(out_index), 64'd15);
    check("r_last1",  64'(out_last), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    check("r_valid", 64'(out_valid), 64'd0);
    check("r_ready", 64'(load_ready), 64'd1);
    check("r_done",  64'(done), 64'd0);
    check("r_total", 64'(total), 64'd0);
    step();
    check("r_done_late", 64'(done), 64'd0);

    // load_valid held in ISSUE with a new vector; accepted when done is high
    candidate_list = 16'hC000; load_valid = 1'b1; out_ready = 1'b1;
    step();
    candidate_list = 16'h0007;
    check("h_index0", 64'(out_index), 64'd0);
    step();
    check("h_index1", 64'(out_index), 64'd1);
    check("h_total1", 64'(total), 64'd2);
    step();
    check("h_done",  64'(done), 64'd1);
    check("h_valid", 64'(out_valid), 64'd0);
    step();
    load_valid = 1'b0;
    check("h_b_index0", 64'(out_index), 64'd13);
    check("h_b_total",  64'(total), 64'd3);
    step();
    check("h_b_index1", 64'(out_index), 64'd14);
    step();
    check("h_b_index2", 64'(out_index), 64'd15);
    check("h_b_last",   64'(out_last), 64'd1);
    step();
    check("h_b_done", 64'(done), 64'd1);
    out_ready = 1'b0;

`ifdef CANDIDATE_ISSUER_SLOT_EN
    // Slot ordinal tracks the issue order
    step();
    candidate_list = 16'h0110; load_valid = 1'b1; out_ready = 1'b1;
    step();
    load_valid = 1'b0;
    check("s_index0", 64'(out_index), 64'd7);
    check("s_slot0",  64'(out_slot), 64'd0);
    step();
    check("s_index1", 64'(out_index), 64'd11);
    check("s_slot1",  64'(out_slot), 64'd1);
    check("s_last1",  64'(out_last), 64'd1);
    step();
    out_ready = 1'b0;
    check("s_done", 64'(done), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
